// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, pixel formats and the buffer-swap state type
// for the camera frame-buffer read path.
package fb_pkg;

  localparam int FB_WIDTH  = 240;
  localparam int FB_HEIGHT = 320;
  localparam int FB_ADDR_W = 17;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Timing bundle carried alongside the BRAM read so it stays cycle-aligned.
  typedef struct packed {
    logic rd;
    logic hsync;
    logic vsync;
    logic active;
  } sideband_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

  // Bit replication maps full-scale 565 components onto full-scale 888.
  function automatic rgb888_t rgb565_to_888(rgb565_t p);
    rgb888_t o;
    o.r = {p.r, p.r[4:2]};
    o.g = {p.g, p.g[5:4]};
    o.b = {p.b, p.b[4:2]};
    return o;
  endfunction

endpackage

// File: rtl/fb_read_pipeline_if.sv
// BRAM read port between the frame-buffer read pipeline (master) and the
// double-buffered camera frame buffer (slave).
interface fb_read_pipeline_if
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W
) ();

  logic [ADDR_W-1:0] fb_addr;
  logic              fb_sel;
  logic              fb_rd_en;
  logic [15:0]       fb_data;

  modport master (output fb_addr, output fb_sel, output fb_rd_en, input fb_data);
  modport slave  (input fb_addr, input fb_sel, input fb_rd_en, output fb_data);

endinterface

// File: rtl/sideband_delay.sv
// Fixed-depth shift register with synchronous active-low reset, used to carry
// timing flags across the BRAM read latency.
module sideband_delay #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: every stage is cleared on reset so stale sync flags never leak out
  // after reset release; this is a small shift register, not a RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fb_read_pipeline.sv
// Camera frame-buffer read pipeline: scaled coordinates -> BRAM address, timing
// aligned to the BRAM latency, RGB565 -> RGB888, and frame-boundary buffer swap.
module fb_read_pipeline
  import fb_pkg::*;
#(
  parameter int RAM_LATENCY = 2
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [10:0]         hcount_in,
  input  logic [9:0]          vcount_in,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                active_draw_in,
  input  logic [10:0]         scaled_hcount_in,
  input  logic [9:0]          scaled_vcount_in,
  input  logic                valid_addr_in,
  input  logic                frame_ready_in,
  output logic                frame_ack_out,
  output logic                write_buf_out,
  output logic                display_buf_out,
  fb_read_pipeline_if.master  fb_bus,
  output logic [7:0]          red_out,
  output logic [7:0]          green_out,
  output logic [7:0]          blue_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                active_draw_out
);

  swap_state_t state_q, state_d;
  logic        disp_q, disp_d;
  logic        ack_q, ack_d;
  logic        vsync_prev_q;
  logic        vsync_rise;

  logic                 rd_a;
  logic [17:0]          addr_full;
  logic [FB_ADDR_W-1:0] addr_q;
  logic                 sel_q;
  sideband_t            side_a_q, side_b;
  rgb888_t              pix888;
  logic                 unused_inputs;

  // Raw counts are not forwarded; the product never exceeds 17 bits in range.
  assign unused_inputs = ^{hcount_in, vcount_in, addr_full[17]};

  assign vsync_rise = vsync_in & ~vsync_prev_q;

  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave a latch behind.
  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_ready_in && vsync_rise) begin
          disp_d = ~disp_q;
          ack_d  = 1'b1;
        end else if (frame_ready_in) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (vsync_rise) begin
          disp_d  = ~disp_q;
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      disp_q       <= 1'b0;
      ack_q        <= 1'b0;
      vsync_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      disp_q       <= disp_d;
      ack_q        <= ack_d;
      vsync_prev_q <= vsync_in;
    end
  end

  assign frame_ack_out   = ack_q;
  assign display_buf_out = disp_q;
  assign write_buf_out   = ~disp_q;

  assign rd_a      = valid_addr_in & active_draw_in;
  assign addr_full = 18'(scaled_vcount_in) * 18'(FB_WIDTH) + 18'(scaled_hcount_in);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      addr_q   <= '0;
      sel_q    <= 1'b0;
      side_a_q <= '0;
    end else begin
      addr_q   <= rd_a ? addr_full[FB_ADDR_W-1:0] : '0;
      sel_q    <= disp_q;
      side_a_q <= '{rd: rd_a, hsync: hsync_in, vsync: vsync_in, active: active_draw_in};
    end
  end

  assign fb_bus.fb_addr  = addr_q;
  assign fb_bus.fb_sel   = sel_q;
  assign fb_bus.fb_rd_en = side_a_q.rd;

  sideband_delay #(
    .WIDTH ($bits(sideband_t)),
    .DEPTH (RAM_LATENCY)
  ) u_sideband_delay (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .d_i   (side_a_q),
    .q_o   (side_b)
  );

  assign pix888 = rgb565_to_888(rgb565_t'(fb_bus.fb_data));

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      red_out         <= '0;
      green_out       <= '0;
      blue_out        <= '0;
      hsync_out       <= 1'b0;
      vsync_out       <= 1'b0;
      active_draw_out <= 1'b0;
    end else begin
      red_out         <= side_b.rd ? pix888.r : '0;
      green_out       <= side_b.rd ? pix888.g : '0;
      blue_out        <= side_b.rd ? pix888.b : '0;
      hsync_out       <= side_b.hsync;
      vsync_out       <= side_b.vsync;
      active_draw_out <= side_b.active;
    end
  end

endmodule
